// File: rtl/conv_window_gen_if.sv
// rtl/conv_window_gen_if.sv - pixel-in / 3x3-window-out bundle between raster source, window generator and multiply stage
// win_eof exists only when CONV_WINDOW_EOF_EN is defined.
interface conv_window_gen_if #(
  parameter int CNT_W = 10
);
  logic [7:0]       pix_in;
  logic             pix_valid;
  logic             sof;
  logic [7:0]       p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic             win_valid;
  logic [CNT_W-1:0] col_out;
  logic [CNT_W-1:0] row_out;
`ifdef CONV_WINDOW_EOF_EN
  logic             win_eof;
`endif

  // master: the window producer; slave: raster source plus multiply-stage view
  modport master (
    input  pix_in, pix_valid, sof,
    output p1, p2, p3, p4, p5, p6, p7, p8, p9,
    output win_valid, col_out, row_out
`ifdef CONV_WINDOW_EOF_EN
    , output win_eof
`endif
  );

  modport slave (
    output pix_in, pix_valid, sof,
    input  p1, p2, p3, p4, p5, p6, p7, p8, p9,
    input  win_valid, col_out, row_out
`ifdef CONV_WINDOW_EOF_EN
    , input win_eof
`endif
  );
endinterface

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster-to-3x3-window front end with two line buffers
// Optional end-of-frame strobe win_eof enabled by CONV_WINDOW_EOF_EN.
module conv_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CNT_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  conv_window_gen_if.master win
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LAST_COL = cnt_t'(IMG_W - 1);
  localparam cnt_t LAST_ROW = cnt_t'(IMG_H - 1);
  localparam cnt_t ONE      = cnt_t'(1);
  localparam cnt_t TWO      = cnt_t'(2);

  logic [7:0] lb0 [IMG_W];
  logic [7:0] lb1 [IMG_W];

  cnt_t          col_cnt;
  cnt_t          row_cnt;
  cnt_t          cur_col;
  cnt_t          cur_row;
  logic [AW-1:0] idx;
  logic [7:0]    lb0_rd;
  logic [7:0]    lb1_rd;
  logic          in_frame;

  // sof forces the accepted pixel to (0,0) regardless of the running counters
  always_comb begin
    cur_col  = win.sof ? '0 : col_cnt;
    cur_row  = win.sof ? '0 : row_cnt;
    idx      = cur_col[AW-1:0];
    lb0_rd   = lb0[idx];
    lb1_rd   = lb1[idx];
    in_frame = (cur_row >= TWO) && (cur_col >= TWO);
  end

  // Line buffers carry no reset; stale contents only reach windows masked by win_valid
  always_ff @(posedge clk) begin
    if (win.pix_valid) begin
      lb1[idx] <= lb0_rd;
      lb0[idx] <= win.pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt       <= '0;
      row_cnt       <= '0;
      win.p1        <= '0;
      win.p2        <= '0;
      win.p3        <= '0;
      win.p4        <= '0;
      win.p5        <= '0;
      win.p6        <= '0;
      win.p7        <= '0;
      win.p8        <= '0;
      win.p9        <= '0;
      win.win_valid <= 1'b0;
      win.col_out   <= '0;
      win.row_out   <= '0;
`ifdef CONV_WINDOW_EOF_EN
      win.win_eof   <= 1'b0;
`endif
    end else if (win.pix_valid) begin
      win.p1 <= win.p2;
      win.p2 <= win.p3;
      win.p3 <= lb1_rd;
      win.p4 <= win.p5;
      win.p5 <= win.p6;
      win.p6 <= lb0_rd;
      win.p7 <= win.p8;
      win.p8 <= win.p9;
      win.p9 <= win.pix_in;

      win.win_valid <= in_frame;
      win.col_out   <= cur_col - ONE;
      win.row_out   <= cur_row - ONE;
`ifdef CONV_WINDOW_EOF_EN
      win.win_eof   <= (cur_row == LAST_ROW) && (cur_col == LAST_COL);
`endif

      if (cur_col == LAST_COL) begin
        col_cnt <= '0;
        row_cnt <= (cur_row == LAST_ROW) ? '0 : cur_row + ONE;
      end else begin
        col_cnt <= cur_col + ONE;
        row_cnt <= cur_row;
      end
    end else begin
      win.win_valid <= 1'b0;
`ifdef CONV_WINDOW_EOF_EN
      win.win_eof   <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - scoreboarded bench for conv_window_gen on a 4x4 frame
// Expected windows come from a constant table offset by each frame's pixel base.
module tb_conv_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  typedef struct packed {
    logic [8:0][7:0] p;
    logic [9:0]      col;
    logic [9:0]      row;
    logic            eof;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  win_t exp_tab [4];
  win_t sb_q [$];

  conv_window_gen_if #(.CNT_W(10)) win_if ();

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .CNT_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .win (win_if)
  );

  always #5 clk = ~clk;

  function automatic win_t mk(input int a1, a2, a3, a4, a5, a6, a7, a8, a9,
                              input int col, row, input bit eof);
    win_t w;
    w.p[0] = 8'(a1); w.p[1] = 8'(a2); w.p[2] = 8'(a3);
    w.p[3] = 8'(a4); w.p[4] = 8'(a5); w.p[5] = 8'(a6);
    w.p[6] = 8'(a7); w.p[7] = 8'(a8); w.p[8] = 8'(a9);
    w.col  = 10'(col);
    w.row  = 10'(row);
    w.eof  = eof;
    return w;
  endfunction

  function automatic win_t sample();
    win_t w;
    w.p   = {win_if.p9, win_if.p8, win_if.p7, win_if.p6, win_if.p5,
             win_if.p4, win_if.p3, win_if.p2, win_if.p1};
    w.col = win_if.col_out;
    w.row = win_if.row_out;
`ifdef CONV_WINDOW_EOF_EN
    w.eof = win_if.win_eof;
`else
    w.eof = 1'b0;
`endif
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst && win_if.win_valid) begin
      win_t got;
      win_t e;
      got = sample();
      vec_cnt++;
      if (sb_q.size() == 0) begin
        miss_cnt++;
        $display("FAIL unexpected_window: got %h, required no window", got);
      end else begin
        e = sb_q.pop_front();
`ifndef CONV_WINDOW_EOF_EN
        e.eof = 1'b0;
`endif
        if (got !== e) begin
          miss_cnt++;
          $display("FAIL window: got %h, required %h", got, e);
        end
      end
    end
`ifdef CONV_WINDOW_EOF_EN
    if (rst && !win_if.win_valid) begin
      vec_cnt++;
      if (win_if.win_eof !== 1'b0) begin
        miss_cnt++;
        $display("FAIL eof_without_window: got %b, required 0", win_if.win_eof);
      end
    end
`endif
  end

  task automatic check_zero(input string name);
    win_t got;
    got = sample();
    vec_cnt++;
    if (got !== '0 || win_if.win_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL %s: got %h valid %b, required all zero", name, got, win_if.win_valid);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      win_if.pix_valid = 1'b0;
      win_if.sof       = 1'b0;
    end
  endtask

  // Drives npix pixels of a frame (value base+4r+c+1) and pushes the window each completes
  task automatic send_frame(input int base, input int gap, input bit with_sof, input int npix);
    for (int i = 0; i < npix; i++) begin
      int r;
      int c;
      r = i / W;
      c = i % W;
      @(posedge clk); #1;
      win_if.pix_valid = 1'b1;
      win_if.pix_in    = 8'(base + W * r + c + 1);
      win_if.sof       = with_sof && (i == 0);
      if (r >= 2 && c >= 2) begin
        win_t e;
        e = exp_tab[(r - 2) * 2 + (c - 2)];
        for (int j = 0; j < 9; j++) e.p[j] = e.p[j] + 8'(base);
        sb_q.push_back(e);
      end
      if (gap > 0) idle(gap);
    end
  endtask

  initial begin
    exp_tab[0] = mk(1, 2, 3, 5, 6, 7, 9, 10, 11, 1, 1, 1'b0);
    exp_tab[1] = mk(2, 3, 4, 6, 7, 8, 10, 11, 12, 2, 1, 1'b0);
    exp_tab[2] = mk(5, 6, 7, 9, 10, 11, 13, 14, 15, 1, 2, 1'b0);
    exp_tab[3] = mk(6, 7, 8, 10, 11, 12, 14, 15, 16, 2, 2, 1'b1);

    win_if.pix_in    = '0;
    win_if.pix_valid = 1'b0;
    win_if.sof       = 1'b0;

    #1 check_zero("reset_state");
    @(posedge clk); #1 rst = 1'b1;
    idle(2);
    check_zero("idle_after_reset");

    // basic frame, continuous valid
    send_frame(0, 0, 1'b1, W * H);
    idle(4);

    // gapped input
    send_frame(0, 3, 1'b1, W * H);
    idle(4);

    // back-to-back frames, sof only on the first
    send_frame(0, 0, 1'b1, W * H);
    send_frame(16, 0, 1'b0, W * H);
    idle(4);

    // resync: partial frame up to (1,1), sof lands where (1,2) would be
    send_frame(100, 0, 1'b1, W + 2);
    send_frame(0, 0, 1'b1, W * H);
    idle(4);

    // reset mid-frame while pixel (2,3) is on the bus
    send_frame(0, 0, 1'b1, 2 * W + 3);
    @(posedge clk); #1;
    win_if.pix_valid = 1'b1;
    win_if.pix_in    = 8'd12;
    @(negedge clk); #1;
    rst = 1'b0;
    #1 check_zero("async_reset");
    @(posedge clk); #1;
    win_if.pix_valid = 1'b0;
    rst = 1'b1;
    check_zero("after_reset_release");
    send_frame(0, 0, 1'b1, W * H);
    idle(4);

    vec_cnt++;
    if (sb_q.size() != 0) begin
      miss_cnt++;
      $display("FAIL missing_windows: got %0d left over, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
